alu_arbiter: RTL

//  Shares the single alu instance between NUM_REQ requesters (e.g. execute stage, address-gen, debug unit).

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between NUM_REQ requesters.
// One op in flight: accept -> EXEC (alu driven from capture regs) -> RESP (held until taken).
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned OPSEL_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*OPSEL_WIDTH-1:0]  req_opSel,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_Z,
    output logic                            rsp_overflow,
    output logic [DATA_WIDTH-1:0]           alu_bus_a,
    output logic [DATA_WIDTH-1:0]           alu_bus_b,
    output logic [OPSEL_WIDTH-1:0]          alu_opSel,
    input  logic [DATA_WIDTH-1:0]           alu_out,
    input  logic                            alu_Z,
    input  logic                            alu_overflow
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        gnt_q;
    logic [DATA_WIDTH-1:0]   bus_a_q;
    logic [DATA_WIDTH-1:0]   bus_b_q;
    logic [OPSEL_WIDTH-1:0]  opsel_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_z_q;
    logic                    rsp_ovf_q;

    logic [DATA_WIDTH-1:0]   a_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr   [NUM_REQ];
    logic [OPSEL_WIDTH-1:0]  op_arr  [NUM_REQ];

    logic                    found;
    logic [PTR_W-1:0]        win;
    logic [PTR_W-1:0]        rr_ptr_d;
    logic                    accept_en;
    logic                    accept;
    int unsigned             idx;

    // Unpack the flat requester buses into per-requester slices
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g]  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
        assign op_arr[g] = req_opSel[g*OPSEL_WIDTH +: OPSEL_WIDTH];
    end

    // Winner search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // A new op may be accepted from IDLE, or from RESP in the cycle the response is taken
    always_comb begin
        accept_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready[gnt_q]);
        accept    = accept_en && found;
        req_ready = accept ? (NUM_REQ'(1) << win) : '0;
        rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
        rr_ptr_d  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : (win + PTR_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            opsel_q    <= '0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus_a_q  <= a_arr[win];
                        bus_b_q  <= b_arr[win];
                        opsel_q  <= op_arr[win];
                        gnt_q    <= win;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q <= alu_out;
                    rsp_z_q    <= alu_Z;
                    rsp_ovf_q  <= alu_overflow;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        if (accept) begin
                            bus_a_q  <= a_arr[win];
                            bus_b_q  <= b_arr[win];
                            opsel_q  <= op_arr[win];
                            gnt_q    <= win;
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= EXEC;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // alu inputs come straight from the capture registers and hold between ops
    assign alu_bus_a    = bus_a_q;
    assign alu_bus_b    = bus_b_q;
    assign alu_opSel    = opsel_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_Z        = rsp_z_q;
    assign rsp_overflow = rsp_ovf_q;

endmodule
